// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector: takes a pattern/window/overlap
// config, counts pattern matches over a window of qualified bits, then reports done.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic             inp_valid,
    input  logic             inp_bit,
    output logic             busy,
    output logic             match_pulse,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   pattern_q;
    logic [WIN_W-1:0]   window_q;
    logic               overlap_q;
    logic [PAT_W-1:0]   history;
    logic [FILL_W-1:0]  fill;
    logic [WIN_W-1:0]   bits_left;

    logic [PAT_W-1:0]   hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic               hit;
    logic               last_bit;

    assign cfg_ready = (state == S_IDLE) || (state == S_ARMED);

    // Look-ahead of the history/fill as they will be once the current bit is taken.
    always_comb begin
        hist_next = {history[PAT_W-2:0], inp_bit};
        fill_next = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
        hit       = (fill_next == FILL_W'(PAT_W)) && (hist_next == pattern_q);
        last_bit  = (window_q != '0) && (bits_left == WIN_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pattern_q   <= '0;
            window_q    <= '0;
            overlap_q   <= 1'b0;
            history     <= '0;
            fill        <= '0;
            bits_left   <= '0;
            busy        <= 1'b0;
            match_pulse <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE, S_ARMED: begin
                    // A config transfer takes priority over a start in the same cycle.
                    if (cfg_valid) begin
                        pattern_q <= cfg_pattern;
                        window_q  <= cfg_window;
                        overlap_q <= cfg_overlap;
                        state     <= S_ARMED;
                    end else if ((state == S_ARMED) && start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        match_count <= '0;
                        overflow    <= 1'b0;
                        history     <= '0;
                        fill        <= '0;
                        bits_left   <= window_q;
                    end
                end
                S_RUN: begin
                    if (inp_valid) begin
                        history <= hist_next;
                        if (window_q != '0) begin
                            bits_left <= bits_left - 1'b1;
                        end
                        if (hit) begin
                            match_pulse <= 1'b1;
                            if (&match_count) begin
                                overflow <= 1'b1;
                            end else begin
                                match_count <= match_count + 1'b1;
                            end
                            fill <= overlap_q ? fill_next : '0;
                        end else begin
                            fill <= fill_next;
                        end
                    end
                    // Abort still lets a bit accepted in the same cycle be processed above.
                    if (abort || (inp_valid && last_bit)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_ARMED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: two instances (4-bit pattern/8-bit count and
// 2-bit pattern/2-bit count) checked every cycle against a behavioural model.
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cfg_valid_i[2];
    logic [15:0] pat_i[2];
    logic [15:0] win_i[2];
    logic        ovl_i[2];
    logic        start_i[2];
    logic        abort_i[2];
    logic        iv_i[2];
    logic        ib_i[2];

    logic       rdy_a, busy_a, mp_a, done_a, ovf_a;
    logic [7:0] cnt_a;
    logic       rdy_b, busy_b, mp_b, done_b, ovf_b;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid_i[0]), .cfg_ready(rdy_a),
        .cfg_pattern(pat_i[0][3:0]), .cfg_window(win_i[0]), .cfg_overlap(ovl_i[0]),
        .start(start_i[0]), .abort(abort_i[0]),
        .inp_valid(iv_i[0]), .inp_bit(ib_i[0]),
        .busy(busy_a), .match_pulse(mp_a), .done(done_a),
        .match_count(cnt_a), .overflow(ovf_a)
    );

    seq_detect_ctrl #(.PAT_W(2), .CNT_W(2), .WIN_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid_i[1]), .cfg_ready(rdy_b),
        .cfg_pattern(pat_i[1][1:0]), .cfg_window(win_i[1]), .cfg_overlap(ovl_i[1]),
        .start(start_i[1]), .abort(abort_i[1]),
        .inp_valid(iv_i[1]), .inp_bit(ib_i[1]),
        .busy(busy_b), .match_pulse(mp_b), .done(done_b),
        .match_count(cnt_b), .overflow(ovf_b)
    );

    // Behavioural model: phase 0 idle, 1 armed, 2 running, 3 reporting.
    int pw[2]   = '{4, 2};
    int cmax[2] = '{255, 3};
    int phase[2] = '{0, 0};
    int mpat[2]  = '{0, 0};
    int mwin[2]  = '{0, 0};
    bit movl[2]  = '{0, 0};
    int seen[2]  = '{0, 0};
    int recent[2] = '{0, 0};
    int taken[2] = '{0, 0};
    int e_cnt[2] = '{0, 0};
    bit e_ovf[2] = '{0, 0};
    bit e_mp[2]  = '{0, 0};
    bit e_dn[2]  = '{0, 0};

    task automatic model_reset(int k);
        phase[k] = 0; mpat[k] = 0; mwin[k] = 0; movl[k] = 0;
        seen[k] = 0; recent[k] = 0; taken[k] = 0;
        e_cnt[k] = 0; e_ovf[k] = 0; e_mp[k] = 0; e_dn[k] = 0;
    endtask

    task automatic model_step(int k);
        int mask;
        mask = (1 << pw[k]) - 1;
        e_mp[k] = 0;
        e_dn[k] = 0;
        case (phase[k])
            0, 1: begin
                if (cfg_valid_i[k]) begin
                    mpat[k] = int'(pat_i[k]) & mask;
                    mwin[k] = int'(win_i[k]);
                    movl[k] = ovl_i[k];
                    phase[k] = 1;
                end else if (phase[k] == 1 && start_i[k]) begin
                    phase[k] = 2;
                    e_cnt[k] = 0; e_ovf[k] = 0;
                    seen[k] = 0; recent[k] = 0; taken[k] = 0;
                end
            end
            2: begin
                if (iv_i[k]) begin
                    recent[k] = ((recent[k] << 1) | int'(ib_i[k])) & mask;
                    seen[k]++;
                    taken[k]++;
                    if (seen[k] >= pw[k] && recent[k] == mpat[k]) begin
                        e_mp[k] = 1;
                        if (e_cnt[k] == cmax[k]) e_ovf[k] = 1;
                        else e_cnt[k]++;
                        if (!movl[k]) seen[k] = 0;
                    end
                end
                if (abort_i[k] || (iv_i[k] && mwin[k] != 0 && taken[k] == mwin[k])) begin
                    phase[k] = 3;
                    e_dn[k] = 1;
                end
            end
            default: phase[k] = 1;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_val(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic compare_inst(int k, logic r, logic b, logic m, logic d, int c, logic o);
        string p;
        p = (k == 0) ? "a" : "b";
        check_val({p, ".cfg_ready"}, int'(r), int'(phase[k] <= 1));
        check_val({p, ".busy"}, int'(b), int'(phase[k] == 2));
        check_val({p, ".match_pulse"}, int'(m), int'(e_mp[k]));
        check_val({p, ".done"}, int'(d), int'(e_dn[k]));
        check_val({p, ".match_count"}, c, e_cnt[k]);
        check_val({p, ".overflow"}, int'(o), int'(e_ovf[k]));
    endtask

    always @(negedge clk) begin
        compare_inst(0, rdy_a, busy_a, mp_a, done_a, int'(cnt_a), ovf_a);
        compare_inst(1, rdy_b, busy_b, mp_b, done_b, int'(cnt_b), ovf_b);
    end

    function automatic logic get_rdy(int k);
        return (k == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic int get_cnt(int k);
        return (k == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    function automatic logic get_done(int k);
        return (k == 0) ? done_a : done_b;
    endfunction

    task automatic clear_inputs(int k);
        cfg_valid_i[k] = 0; pat_i[k] = '0; win_i[k] = '0; ovl_i[k] = 0;
        start_i[k] = 0; abort_i[k] = 0; iv_i[k] = 0; ib_i[k] = 0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic configure(int k, logic [15:0] p, int w, bit o);
        int guard;
        guard = 0;
        while (!get_rdy(k) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("cfg.ready_wait", int'(get_rdy(k)), 1);
        cfg_valid_i[k] = 1; pat_i[k] = p; win_i[k] = w[15:0]; ovl_i[k] = o;
        @(negedge clk);
        cfg_valid_i[k] = 0;
    endtask

    task automatic start_run(int k);
        start_i[k] = 1;
        @(negedge clk);
        start_i[k] = 0;
    endtask

    task automatic send_bit(int k, bit b, bit ab);
        iv_i[k] = 1; ib_i[k] = b; abort_i[k] = ab;
        @(negedge clk);
        iv_i[k] = 0; abort_i[k] = 0;
    endtask

    // Runs a full window of n bits (MSB of bits first) and checks done on the last one.
    task automatic run_stream(int k, logic [15:0] p, int w, bit o, logic [31:0] bits, int n);
        configure(k, p, w, o);
        start_run(k);
        for (int i = n - 1; i >= 0; i--) send_bit(k, bits[i], 0);
        check_val("stream.done", int'(get_done(k)), 1);
    endtask

    task automatic wait_armed(int k);
        int guard;
        guard = 0;
        while (!get_rdy(k) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("armed.wait", int'(get_rdy(k)), 1);
    endtask

    initial begin
        logic [7:0] bits;
        logic [7:0] exp_p;
        clear_inputs(0);
        clear_inputs(1);
        reset = 1'b0;
        #1;
        check_val("reset.cfg_ready", int'(rdy_a), 1);
        check_val("reset.busy", int'(busy_a), 0);
        check_val("reset.match_count", int'(cnt_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_cycle();

        $display("[TB] scenario 1: pattern 1011 window 8 overlapping");
        configure(0, 16'hB, 8, 1);
        start_run(0);
        bits  = 8'b1011_0111;
        exp_p = 8'b0001_0010;
        for (int i = 7; i >= 0; i--) begin
            send_bit(0, bits[i], 0);
            check_val("t1.match_pulse", int'(mp_a), int'(exp_p[i]));
            check_val("t1.done", int'(done_a), int'(i == 0));
        end
        check_val("t1.match_count", int'(cnt_a), 2);

        $display("[TB] scenario 2: overlap modes");
        run_stream(0, 16'hB, 7, 1, 32'b101_1011, 7);
        check_val("t2.ovl1_count", get_cnt(0), 2);
        run_stream(0, 16'hB, 7, 0, 32'b101_1011, 7);
        check_val("t2.ovl0_count", get_cnt(0), 1);
        run_stream(1, 16'h3, 4, 1, 32'b1111, 4);
        check_val("t2.p11_ovl1_count", get_cnt(1), 3);
        run_stream(1, 16'h3, 4, 0, 32'b1111, 4);
        check_val("t2.p11_ovl0_count", get_cnt(1), 2);

        $display("[TB] scenario 3: input gaps");
        configure(0, 16'hB, 8, 1);
        start_run(0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(0, bits[i], 0);
            check_val("t3.done", int'(done_a), int'(i == 0));
            if (i > 0) begin
                idle_cycle();
                check_val("t3.gap_busy", int'(busy_a), 1);
            end
        end
        check_val("t3.match_count", int'(cnt_a), 2);

        $display("[TB] scenario 4: unbounded window with abort");
        configure(0, 16'hB, 0, 1);
        start_run(0);
        for (int i = 0; i < 20; i++) send_bit(0, 1'($urandom_range(0, 1)), 0);
        check_val("t4.busy_after_20", int'(busy_a), 1);
        send_bit(0, 1, 0);
        send_bit(0, 0, 0);
        send_bit(0, 1, 0);
        send_bit(0, 1, 1);
        check_val("t4.final_pulse", int'(mp_a), 1);
        check_val("t4.done", int'(done_a), 1);
        idle_cycle();
        check_val("t4.armed_ready", int'(rdy_a), 1);
        start_run(0);
        check_val("t4.restart_count", int'(cnt_a), 0);
        abort_i[0] = 1;
        idle_cycle();
        abort_i[0] = 0;
        wait_armed(0);

        $display("[TB] scenario 5: saturation and overflow");
        configure(1, 16'h3, 6, 1);
        start_run(1);
        for (int i = 1; i <= 6; i++) begin
            send_bit(1, 1, 0);
            if (i == 4) begin
                check_val("t5.count_at_3rd", int'(cnt_b), 3);
                check_val("t5.ovf_at_3rd", int'(ovf_b), 0);
            end
            if (i == 5) check_val("t5.ovf_at_4th", int'(ovf_b), 1);
        end
        check_val("t5.done", int'(done_b), 1);
        repeat (3) idle_cycle();
        check_val("t5.hold_count", int'(cnt_b), 3);
        check_val("t5.hold_ovf", int'(ovf_b), 1);

        $display("[TB] scenario 6: handshakes and reset");
        configure(0, 16'hB, 5, 1);
        start_run(0);
        cfg_valid_i[0] = 1; pat_i[0] = 16'h6;
        for (int i = 0; i < 5; i++) begin
            send_bit(0, 1, 0);
            check_val("t6.ready_in_run", int'(rdy_a), 0);
        end
        check_val("t6.done", int'(done_a), 1);
        idle_cycle();
        check_val("t6.ready_after_done", int'(rdy_a), 1);
        idle_cycle();
        cfg_valid_i[0] = 0;
        cfg_valid_i[0] = 1; pat_i[0] = 16'hB; win_i[0] = 16'd5; start_i[0] = 1;
        idle_cycle();
        cfg_valid_i[0] = 0; start_i[0] = 0;
        check_val("t6.cfg_start_busy", int'(busy_a), 0);
        check_val("t6.cfg_start_ready", int'(rdy_a), 1);
        start_run(0);
        check_val("t6.run_busy", int'(busy_a), 1);
        send_bit(0, 1, 0);
        send_bit(0, 0, 0);
        send_bit(0, 1, 0);
        send_bit(0, 1, 0);
        check_val("t6.count_before_reset", int'(cnt_a), 1);
        #2 reset = 1'b0;
        #1;
        check_val("t6.rst_busy", int'(busy_a), 0);
        check_val("t6.rst_count", int'(cnt_a), 0);
        check_val("t6.rst_done", int'(done_a), 0);
        check_val("t6.rst_pulse", int'(mp_a), 0);
        check_val("t6.rst_ready", int'(rdy_a), 1);
        @(negedge clk);
        reset = 1'b1;
        clear_inputs(0);
        clear_inputs(1);
        idle_cycle();

        $display("[TB] random phase");
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                cfg_valid_i[k] = ($urandom_range(0, 15) == 0);
                pat_i[k]       = 16'($urandom_range(0, 65535));
                win_i[k]       = 16'($urandom_range(0, 12));
                ovl_i[k]       = 1'($urandom_range(0, 1));
                start_i[k]     = ($urandom_range(0, 3) == 0);
                abort_i[k]     = ($urandom_range(0, 39) == 0);
                iv_i[k]        = ($urandom_range(0, 9) < 7);
                ib_i[k]        = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        clear_inputs(0);
        clear_inputs(1);
        repeat (3) idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
